moore_nonoverlap_1101: RTL and testbench

//   Moore FSM that detects the serial bit pattern 1-1-0-1 on a 1-bit input

---
 rtl/moore_nonoverlap_1101.sv | 69 ++++++
 tb/tb_moore_nonoverlap_1101.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/moore_nonoverlap_1101.sv
// moore_nonoverlap_1101
//   Moore detector for the serial pattern 1-1-0-1 (first bit earliest in time).
//   Detection is non-overlapping: after a match the search restarts from
//   scratch, and no bit of the matched pattern is reused as a new prefix.
//
// Ports
//   clk  in   system clock, rising edge
//   rst  in   asynchronous reset, active low
//   in   in   serial data bit, sampled on each rising clk edge
//   out  out  detect flag, high for one cycle while in S1101
//
// state  | meaning
// -------+-----------------------------
// S0     | idle, no partial match
// S1     | seen 1
// S11    | seen 11 (further 1s stay here)
// S110   | seen 110
// S1101  | match, out = 1
module moore_nonoverlap_1101 (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam logic [2:0] S0    = 3'b000;
    localparam logic [2:0] S1    = 3'b001;
    localparam logic [2:0] S11   = 3'b010;
    localparam logic [2:0] S110  = 3'b011;
    localparam logic [2:0] S1101 = 3'b100;

    logic [2:0] state;
    logic [2:0] state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    // An unknown 'in' falls through to the else branches, i.e. it acts as 0.
    always_comb begin
        state_nxt = S0;
        case (state)
            S0:    if (in) state_nxt = S1;    else state_nxt = S0;
            S1:    if (in) state_nxt = S11;   else state_nxt = S0;
            S11:   if (in) state_nxt = S11;   else state_nxt = S110;
            S110:  if (in) state_nxt = S1101; else state_nxt = S0;
            // After a match the trailing 1 is not reused as a prefix; the
            // incoming bit starts a fresh search.
            S1101: if (in) state_nxt = S1;    else state_nxt = S0;
            default: state_nxt = S0;
        endcase
    end

    assign out = (state == S1101);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert (!$isunknown(in))
                else $error("moore_nonoverlap_1101: unknown value on in");
        end
    end
`endif

endmodule

// File: tb/tb_moore_nonoverlap_1101.sv
module tb_moore_nonoverlap_1101;

    logic clk;
    logic rst;
    logic in;
    logic out;

    int n_assert = 0;
    int n_fail   = 0;

    moore_nonoverlap_1101 dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic exp);
        n_assert++;
        assert (out === exp)
            else begin
                n_fail++;
                $error("FAIL %s: out=%b required=%b", tag, out, exp);
            end
    endtask

    task automatic check_state(input string tag, input logic [2:0] exp);
        n_assert++;
        assert (dut.state === exp)
            else begin
                n_fail++;
                $error("FAIL %s: state=%b required=%b", tag, dut.state, exp);
            end
    endtask

    // Present one bit, let the rising edge sample it, then check out 1 ns later.
    task automatic send(input logic b, input logic exp, input string tag);
        in = b;
        @(posedge clk);
        #1;
        check_out(tag, exp);
    endtask

    // Apply a short reset aligned away from the clock edge.
    task automatic do_reset();
        rst = 1'b0;
        in  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Reference model: sliding 4-bit window that is cleared after each match.
    logic [3:0] m_hist;
    int         m_len;
    logic       m_exp;

    task automatic model_step(input logic b);
        m_hist = {m_hist[2:0], b};
        if (m_len < 4) m_len++;
        m_exp = (m_len >= 4) && (m_hist == 4'b1101);
        if (m_exp) begin
            m_hist = 4'b0000;
            m_len  = 0;
        end
    endtask

    logic [13:0] pat2;
    logic [6:0]  pat3;
    logic [5:0]  pat4;
    logic        rb;

    initial begin
        rst = 1'b0;
        in  = 1'b0;
        #1;

        // 1. reset held, then idle zeros
        check_state("reset_async", 3'b000);
        check_out("reset_async_out", 1'b0);
        for (int i = 0; i < 2; i++) begin
            in = ~in;
            @(posedge clk);
            #1;
            check_state("reset_held", 3'b000);
            check_out("reset_held_out", 1'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0, "idle_zero");
            check_state("idle_state", 3'b000);
        end

        // 2. stream with matches ending at bits 7 and 12
        pat2 = 14'b01011010110101;
        for (int i = 0; i < 14; i++) begin
            send(pat2[13 - i], (i == 6) || (i == 11), "stream2");
        end

        // 3. 1101101: only the first match counts
        do_reset();
        pat3 = 7'b1101101;
        for (int i = 0; i < 7; i++) begin
            send(pat3[6 - i], (i == 3), "nonoverlap");
        end

        // 4. 111101: S11 self-loop
        do_reset();
        pat4 = 6'b111101;
        for (int i = 0; i < 6; i++) begin
            send(pat4[5 - i], (i == 5), "s11_loop");
        end

        // 5. asynchronous reset while in S110
        do_reset();
        send(1'b1, 1'b0, "pre_rst_1");
        send(1'b1, 1'b0, "pre_rst_2");
        send(1'b0, 1'b0, "pre_rst_3");
        check_state("in_s110", 3'b011);
        in = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_state("async_rst", 3'b000);
        check_out("async_rst_out", 1'b0);
        @(posedge clk);
        #1;
        check_state("async_rst_hold", 3'b000);
        rst = 1'b1;
        send(1'b1, 1'b0, "post_rst_1");
        send(1'b1, 1'b0, "post_rst_2");
        send(1'b1, 1'b0, "post_rst_3");
        send(1'b0, 1'b0, "post_rst_4");
        send(1'b1, 1'b1, "post_rst_match");
        send(1'b0, 1'b0, "post_rst_pulse_end");

        // 6a. illegal encoding recovers to S0; in=1 would lead S1 to S11
        do_reset();
        send(1'b1, 1'b0, "pre_illegal");
        check_state("pre_illegal_state", 3'b001);
        force dut.state = 3'b101;
        #1;
        release dut.state;
        #1;
        check_state("illegal_forced", 3'b101);
        check_out("illegal_out", 1'b0);
        in = 1'b1;
        @(posedge clk);
        #1;
        check_state("illegal_recover", 3'b000);
        check_out("illegal_recover_out", 1'b0);

        // 6b. random stream against the reference model
        do_reset();
        m_hist = 4'b0000;
        m_len  = 0;
        for (int i = 0; i < 1000; i++) begin
            rb = 1'($urandom_range(0, 1));
            model_step(rb);
            send(rb, m_exp, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of stimulus");
        $fatal(1, "timeout");
    end

endmodule
